// File: rtl/seq_gen.sv
// Serial sequence generator: latches a W-bit pattern on start and shifts it out MSB-first,
// repeating it reps+1 times. Define SEQ_GEN_PARITY_EN to append an even-parity bit per repetition.
module seq_gen #(
  parameter int W     = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [W-1:0]     pattern,
  input  logic [CNT_W-1:0] reps,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(W);
  localparam logic [BW-1:0] LastBit = BW'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND
`ifdef SEQ_GEN_PARITY_EN
    ,
    PAR
`endif
  } state_t;

  state_t           state_q;
  logic [W-1:0]     shiftReg_q;
  logic [W-1:0]     savedPat_q;
  logic [CNT_W-1:0] repCnt_q;
  logic [BW-1:0]    bitCnt_q;
  logic             x_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;

  // bitCnt_q tracks which pattern bit is on x, so the end-of-frame decision is
  // taken on the edge that retires bit W-1 (or the parity bit) and the next
  // frame's MSB appears with no gap cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      shiftReg_q <= '0;
      savedPat_q <= '0;
      repCnt_q   <= '0;
      bitCnt_q   <= '0;
      x_q        <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            savedPat_q <= pattern;
            shiftReg_q <= pattern << 1;
            repCnt_q   <= reps;
            bitCnt_q   <= '0;
            x_q        <= pattern[W-1];
            valid_q    <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= SEND;
          end else begin
            x_q     <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          if (state_q == SEND && bitCnt_q != LastBit) begin
            x_q        <= shiftReg_q[W-1];
            shiftReg_q <= shiftReg_q << 1;
            bitCnt_q   <= bitCnt_q + 1'b1;
          end
`ifdef SEQ_GEN_PARITY_EN
          else if (state_q == SEND) begin
            x_q     <= ^savedPat_q;
            state_q <= PAR;
          end
`endif
          else if (repCnt_q != '0) begin
            repCnt_q   <= repCnt_q - 1'b1;
            shiftReg_q <= savedPat_q << 1;
            x_q        <= savedPat_q[W-1];
            bitCnt_q   <= '0;
            state_q    <= SEND;
          end else begin
            x_q     <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign x       = x_q;
  assign x_valid = valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_seq_gen.sv
// Scoreboard bench for seq_gen: expected serial bits are queued at stimulus time and
// popped by a monitor whenever x_valid is high; each test checks framing and timing inline.
module tb_seq_gen;

`ifdef SEQ_GEN_PARITY_EN
  localparam int B = 5;
`else
  localparam int B = 4;
`endif

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] pattern;
  logic [3:0] reps;
  logic       x;
  logic       x_valid;
  logic       busy;
  logic       done;

  logic expQ[$];
  logic expBit;
  int   assertCnt = 0;
  int   failCnt   = 0;

  logic [3:0] detHist;
  int         detCnt;
  logic       detClr;
  logic       y;

  seq_gen #(.W(4), .CNT_W(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .pattern (pattern),
    .reps    (reps),
    .x       (x),
    .x_valid (x_valid),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Behavioural 1011 detector standing in for the downstream sequence detector.
  always @(posedge clk or negedge reset) begin
    if (!reset || detClr) begin
      detHist <= 4'b0000;
      detCnt  <= 0;
    end else if (x_valid) begin
      detHist <= {detHist[2:0], x};
      detCnt  <= detCnt + 1;
    end
  end
  assign y = (detCnt >= 4) && (detHist == 4'b1011);

  // Scoreboard monitor: every valid serial bit must match the head of the queue.
  always @(negedge clk) begin
    if (reset === 1'b1 && x_valid === 1'b1) begin
      assertCnt++;
      if (expQ.size() == 0) begin
        failCnt++;
        $display("[TB] FAIL serial_extra: got x=%b with x_valid=1, required no valid bit", x);
      end else begin
        expBit = expQ.pop_front();
        if (x !== expBit) begin
          failCnt++;
          $display("[TB] FAIL serial_bit: got %b required %b", x, expBit);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] pat, input logic [3:0] r);
    start   = 1'b1;
    pattern = pat;
    reps    = r;
    for (int k = 0; k <= int'(r); k++) begin
      for (int i = 3; i >= 0; i--) expQ.push_back(pat[i]);
`ifdef SEQ_GEN_PARITY_EN
      expQ.push_back(pat[3] ^ pat[2] ^ pat[1] ^ pat[0]);
`endif
    end
  endtask

  task automatic waitDone(input int limit, input bit holdStart,
                          output int nValid, output int nBusy, output int doneCyc);
    nValid  = 0;
    nBusy   = 0;
    doneCyc = -1;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (c == 1 && !holdStart) start = 1'b0;
      if (holdStart && c == 2) begin
        pattern = 4'b0000;
        reps    = 4'hF;
      end
      if (x_valid === 1'b1) nValid++;
      if (busy === 1'b1) nBusy++;
      if (done === 1'b1) begin
        doneCyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #10;
    assertCnt++;
    if ({x, x_valid, busy, done} !== 4'b0000) begin
      failCnt++;
      $display("[TB] FAIL reset_hold: got %b required 0000", {x, x_valid, busy, done});
    end
    #5 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      assertCnt++;
      if ({x, x_valid, busy, done} !== 4'b0000) begin
        failCnt++;
        $display("[TB] FAIL reset_idle: got %b required 0000", {x, x_valid, busy, done});
      end
    end
  endtask

  task automatic test_single();
    int nv, nb, dc;
    @(negedge clk);
    applyStimulus(4'b1011, 4'd0);
    waitDone(50, 1'b0, nv, nb, dc);
    assertCnt++;
    if (dc !== B + 1) begin
      failCnt++;
      $display("[TB] FAIL single_done_cycle: got %0d required %0d", dc, B + 1);
    end
    assertCnt++;
    if (nv !== B) begin
      failCnt++;
      $display("[TB] FAIL single_valid_len: got %0d required %0d", nv, B);
    end
    assertCnt++;
    if (nb !== B) begin
      failCnt++;
      $display("[TB] FAIL single_busy_len: got %0d required %0d", nb, B);
    end
    assertCnt++;
    if ({busy, x_valid} !== 2'b00) begin
      failCnt++;
      $display("[TB] FAIL single_done_flags: got busy,x_valid=%b required 00", {busy, x_valid});
    end
    @(negedge clk);
    assertCnt++;
    if (done !== 1'b0) begin
      failCnt++;
      $display("[TB] FAIL single_done_pulse: got done=%b required 0", done);
    end
    assertCnt++;
    if (expQ.size() !== 0) begin
      failCnt++;
      $display("[TB] FAIL single_leftover: got %0d bits pending required 0", expQ.size());
    end
  endtask

  task automatic test_repeat();
    int nv, nb, dc;
    @(negedge clk);
    applyStimulus(4'b0110, 4'd2);
    waitDone(100, 1'b0, nv, nb, dc);
    assertCnt++;
    if (nv !== 3 * B || nb !== 3 * B) begin
      failCnt++;
      $display("[TB] FAIL repeat_len: got valid=%0d busy=%0d required %0d", nv, nb, 3 * B);
    end
    assertCnt++;
    if (dc !== 3 * B + 1) begin
      failCnt++;
      $display("[TB] FAIL repeat_done_cycle: got %0d required %0d", dc, 3 * B + 1);
    end
  endtask

  task automatic test_parity();
    int nv, nb, dc;
    @(negedge clk);
    applyStimulus(4'b1001, 4'd0);
    waitDone(50, 1'b0, nv, nb, dc);
    assertCnt++;
    if (nv !== B || dc !== B + 1) begin
      failCnt++;
      $display("[TB] FAIL parity_frame: got valid=%0d done_cycle=%0d required %0d/%0d", nv, dc, B, B + 1);
    end
  endtask

  task automatic test_max_reps();
    int nv, nb, dc;
    @(negedge clk);
    applyStimulus(4'b1100, 4'hF);
    waitDone(300, 1'b0, nv, nb, dc);
    assertCnt++;
    if (nv !== 16 * B) begin
      failCnt++;
      $display("[TB] FAIL maxreps_len: got %0d required %0d", nv, 16 * B);
    end
    assertCnt++;
    if (dc !== 16 * B + 1) begin
      failCnt++;
      $display("[TB] FAIL maxreps_done_cycle: got %0d required %0d", dc, 16 * B + 1);
    end
  endtask

  task automatic test_start_held();
    int nv, nb, dc;
    @(negedge clk);
    applyStimulus(4'b1011, 4'd0);
    waitDone(50, 1'b1, nv, nb, dc);
    start = 1'b0;
    assertCnt++;
    if (nv !== B || dc !== B + 1) begin
      failCnt++;
      $display("[TB] FAIL held_frame: got valid=%0d done_cycle=%0d required %0d/%0d", nv, dc, B, B + 1);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      assertCnt++;
      if ({busy, x_valid} !== 2'b00) begin
        failCnt++;
        $display("[TB] FAIL held_not_queued: got busy,x_valid=%b required 00", {busy, x_valid});
      end
    end
  endtask

  task automatic test_back_to_back();
    int nv, nb, dc;
    @(negedge clk);
    applyStimulus(4'b1011, 4'd0);
    waitDone(50, 1'b0, nv, nb, dc);
    applyStimulus(4'b0110, 4'd1);
    waitDone(100, 1'b0, nv, nb, dc);
    assertCnt++;
    if (dc !== 2 * B + 1) begin
      failCnt++;
      $display("[TB] FAIL b2b_done_cycle: got %0d required %0d", dc, 2 * B + 1);
    end
    assertCnt++;
    if (nv !== 2 * B) begin
      failCnt++;
      $display("[TB] FAIL b2b_valid_len: got %0d required %0d", nv, 2 * B);
    end
  endtask

  task automatic test_abort();
    @(negedge clk);
    applyStimulus(4'b1011, 4'd3);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    assertCnt++;
    if ({x, x_valid, busy} !== 3'b111) begin
      failCnt++;
      $display("[TB] FAIL abort_midframe: got x,x_valid,busy=%b required 111", {x, x_valid, busy});
    end
    #2 reset = 1'b0;
    #1;
    assertCnt++;
    if ({x, x_valid, busy, done} !== 4'b0000) begin
      failCnt++;
      $display("[TB] FAIL abort_async_clear: got %b required 0000", {x, x_valid, busy, done});
    end
    expQ.delete();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      assertCnt++;
      if ({done, busy, x_valid} !== 3'b000) begin
        failCnt++;
        $display("[TB] FAIL abort_no_done: got done,busy,x_valid=%b required 000", {done, busy, x_valid});
      end
    end
  endtask

  task automatic test_loopback();
    int yCyc = -1;
    @(negedge clk);
    detClr = 1'b1;
    @(negedge clk);
    detClr = 1'b0;
    applyStimulus(4'b1011, 4'd0);
    for (int c = 1; c <= B + 3; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (y === 1'b1 && yCyc < 0) yCyc = c;
    end
    assertCnt++;
    if (yCyc !== 5) begin
      failCnt++;
      $display("[TB] FAIL loopback_y_cycle: got %0d required 5", yCyc);
    end
  endtask

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    pattern = 4'b0000;
    reps    = 4'd0;
    detClr  = 1'b0;
    test_reset();
    test_single();
    test_repeat();
    test_parity();
    test_max_reps();
    test_start_held();
    test_back_to_back();
    test_abort();
    test_loopback();
    @(negedge clk);
    assertCnt++;
    if (expQ.size() !== 0) begin
      failCnt++;
      $display("[TB] FAIL final_leftover: got %0d bits pending required 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
